// File: rtl/shift_pkg.sv
// Shared constants for the LED shift-chain step-enable generator.
package shift_pkg;

    localparam int   N_BITS     = 16;
    localparam int   FAST_DIV   = 4;
    localparam int   SLOW_DIV   = 16;
    localparam int   DEB_CYCLES = 4;

    localparam logic RATE_FAST  = 1'b1;
    localparam logic RATE_SLOW  = 1'b0;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser for the asynchronous rate select, followed by a
// debounce counter that only accepts a new level after DEB_CYCLES
// consecutive mismatching samples. o_chg_now is the combinational
// "rate_q changes on this edge" term so the prescaler can restart on the
// same edge the registered rate_chg pulse is set.
module sync_debounce #(
    parameter int   DEB_CYCLES = shift_pkg::DEB_CYCLES,
    parameter logic RST_RATE   = shift_pkg::RATE_FAST
) (
    input  logic clk,
    input  logic rst,
    input  logic rate_in,
    output logic rate_q,
    output logic rate_chg,
    output logic o_chg_now
);
    import shift_pkg::*;

    localparam int DW = cnt_w(DEB_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_rate_q;
    logic          r_rate_chg;
    logic [DW-1:0] r_cnt;
    logic          w_mismatch;
    logic          w_last;

    // Accept the new level when the run of mismatches reaches DEB_CYCLES
    always_comb begin
        w_mismatch = (r_s2 != r_rate_q);
        w_last     = (r_cnt == DW'(DEB_CYCLES - 1));
        o_chg_now  = w_mismatch && w_last;
    end

    // Metastability guard: rate_in -> s1 -> s2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= RST_RATE;
            r_s2 <= RST_RATE;
        end else begin
            r_s1 <= rate_in;
            r_s2 <= r_s1;
        end
    end

    // Debounce: any matching sample throws away the partial run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rate_q   <= RST_RATE;
            r_rate_chg <= 1'b0;
        end else begin
            r_rate_chg <= 1'b0;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_last) begin
                r_rate_q   <= r_s2;
                r_cnt      <= '0;
                r_rate_chg <= 1'b1;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

    assign rate_q   = r_rate_q;
    assign rate_chg = r_rate_chg;

endmodule

// File: rtl/shift_tick_gen.sv
// Step-enable generator for the LED shift chain: debounced rate select
// plus a prescaler producing a one-cycle tick every FAST_DIV or SLOW_DIV
// cycles. Optional feature macro: SHIFT_TICK_HOLD_EN adds a hold input
// that freezes the prescaler without stopping the debouncer.
module shift_tick_gen #(
    parameter int   FAST_DIV   = shift_pkg::FAST_DIV,
    parameter int   SLOW_DIV   = shift_pkg::SLOW_DIV,
    parameter int   DEB_CYCLES = shift_pkg::DEB_CYCLES,
    parameter logic RST_RATE   = shift_pkg::RATE_FAST
) (
    input  logic clk,
    input  logic rst,
    input  logic rate_in,
`ifdef SHIFT_TICK_HOLD_EN
    input  logic hold,
`endif
    output logic tick,
    output logic rate_q,
    output logic rate_chg
);
    import shift_pkg::*;

    localparam int CW = cnt_w(SLOW_DIV);

    logic          w_rate_q;
    logic          w_chg_now;
    logic          w_hold;
    logic [CW-1:0] w_div_m1;
    logic [CW-1:0] r_cnt;
    logic          r_tick;

    sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .RST_RATE   (RST_RATE)
    ) u_sync_debounce (
        .clk       (clk),
        .rst       (rst),
        .rate_in   (rate_in),
        .rate_q    (w_rate_q),
        .rate_chg  (rate_chg),
        .o_chg_now (w_chg_now)
    );

`ifdef SHIFT_TICK_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // Terminal count for the rate currently in effect
    always_comb begin
        w_div_m1 = (w_rate_q == RATE_FAST) ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);
    end

    // Prescaler: a rate switch restarts the period (and beats a coincident
    // wrap), so the count is always below the new divisor; hold only
    // freezes the count and masks tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_chg_now) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_hold) begin
            r_tick <= 1'b0;
        end else if (r_cnt == w_div_m1) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick   = r_tick;
    assign rate_q = w_rate_q;

endmodule

// File: tb/tb_shift_tick_gen.sv
// Directed bench for shift_tick_gen with default parameters
// (FAST_DIV=4, SLOW_DIV=16, DEB_CYCLES=4, RST_RATE=1).
module tb_shift_tick_gen;

    logic clk;
    logic rst;
    logic rate_in;
`ifdef SHIFT_TICK_HOLD_EN
    logic hold;
`endif
    logic tick;
    logic rate_q;
    logic rate_chg;

    int total;
    int passed;

    shift_tick_gen dut (
        .clk      (clk),
        .rst      (rst),
        .rate_in  (rate_in),
`ifdef SHIFT_TICK_HOLD_EN
        .hold     (hold),
`endif
        .tick     (tick),
        .rate_q   (rate_q),
        .rate_chg (rate_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rate_in = 1'b1;
        repeat (3) step();
        total++;
        if ({tick, rate_chg, rate_q} !== 3'b001)
            $display("FAIL reset_outs got %b want 001", {tick, rate_chg, rate_q});
        else passed++;
        rst = 1'b0;
        // first tick on edge 4, then every 4 edges, 5 ticks
        for (int e = 1; e <= 20; e++) begin
            step();
            total++;
            if (tick !== ((e % 4) == 0) || rate_chg !== 1'b0 || rate_q !== 1'b1)
                $display("FAIL reset_fast e=%0d got t%b c%b q%b want t%b c0 q1",
                         e, tick, rate_chg, rate_q, (e % 4) == 0);
            else passed++;
        end
    endtask

    // Prescaler is at 0 on entry; change applied on edge 6
    task automatic test_rate_change();
        logic et, ec, eq;
        rate_in = 1'b0;
        for (int e = 1; e <= 38; e++) begin
            step();
            et = (e == 4) || (e > 6 && ((e - 6) % 16) == 0);
            ec = (e == 6);
            eq = (e < 6);
            total++;
            if (tick !== et || rate_chg !== ec || rate_q !== eq)
                $display("FAIL rate_change e=%0d got t%b c%b q%b want t%b c%b q%b",
                         e, tick, rate_chg, rate_q, et, ec, eq);
            else passed++;
        end
    endtask

    // Slow count at 0 on entry; the 16th edge is both wrap and rate change
    task automatic test_coincident();
        logic et, ec, eq;
        for (int e = 1; e <= 24; e++) begin
            if (e == 11) rate_in = 1'b1;
            step();
            et = (e == 20) || (e == 24);
            ec = (e == 16);
            eq = (e >= 16);
            total++;
            if (tick !== et || rate_chg !== ec || rate_q !== eq)
                $display("FAIL coincident e=%0d got t%b c%b q%b want t%b c%b q%b",
                         e, tick, rate_chg, rate_q, et, ec, eq);
            else passed++;
        end
    endtask

    // Fast count at 0 on entry; 2-cycle low pulse must change nothing
    task automatic test_glitch();
        rate_in = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 2) rate_in = 1'b1;
            total++;
            if (tick !== ((e % 4) == 0) || rate_chg !== 1'b0 || rate_q !== 1'b1)
                $display("FAIL glitch e=%0d got t%b c%b q%b want t%b c0 q1",
                         e, tick, rate_chg, rate_q, (e % 4) == 0);
            else passed++;
        end
    endtask

    // Go slow, count to 10, reset between edges, then check a clean restart
    task automatic test_reset_mid();
        rate_in = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step();
            total++;
            if (tick !== (e == 4) || rate_chg !== (e == 6) || rate_q !== (e < 6))
                $display("FAIL mid_setup e=%0d got t%b c%b q%b", e, tick, rate_chg, rate_q);
            else passed++;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({tick, rate_chg, rate_q} !== 3'b001)
            $display("FAIL mid_reset_async got %b want 001", {tick, rate_chg, rate_q});
        else passed++;
        rate_in = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            total++;
            if (tick !== ((e % 4) == 0) || rate_chg !== 1'b0 || rate_q !== 1'b1)
                $display("FAIL mid_restart e=%0d got t%b c%b q%b want t%b c0 q1",
                         e, tick, rate_chg, rate_q, (e % 4) == 0);
            else passed++;
        end
    endtask

`ifdef SHIFT_TICK_HOLD_EN
    // Fast count at 0 on entry; freeze at count 2 for 7 cycles
    task automatic test_hold();
        repeat (2) step();
        hold = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            total++;
            if (tick !== 1'b0)
                $display("FAIL hold_masked e=%0d got %b want 0", e, tick);
            else passed++;
        end
        hold = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            total++;
            if (tick !== (e == 2 || e == 6))
                $display("FAIL hold_resume e=%0d got %b want %b", e, tick, (e == 2 || e == 6));
            else passed++;
        end
    endtask
`endif

    initial begin
        total  = 0;
        passed = 0;
`ifdef SHIFT_TICK_HOLD_EN
        hold   = 1'b0;
`endif
        test_reset();
        test_rate_change();
        test_coincident();
        test_glitch();
        test_reset_mid();
`ifdef SHIFT_TICK_HOLD_EN
        test_hold();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
